// File: rtl/sync_bidir_fifo_pkg.sv
// Shared types and constants for the bidirectional FIFO.
// State encoding, direction constants and the steady-state helper.
package bidir_fifo_pkg;

  typedef enum logic [1:0] {
    ST_A2B   = 2'd0,
    ST_B2A   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  localparam logic DIR_A_WRITES = 1'b1;
  localparam logic DIR_B_WRITES = 1'b0;

  function automatic state_t steady_of(input logic d);
    return (d == DIR_A_WRITES) ? ST_A2B : ST_B2A;
  endfunction

endpackage

// File: rtl/sync_bidir_fifo_if.sv
// Port bundle of the bidirectional FIFO: both agents plus status.
// slave = FIFO side, master = the agents driving it.
interface sync_bidir_fifo_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);

  logic             dir_req;
  logic             dir;
  logic             dir_busy;

  logic             a_winc;
  logic [DSIZE-1:0] a_wdata;
  logic             a_rinc;
  logic [DSIZE-1:0] a_rdata;
  logic             a_full;
  logic             a_afull;
  logic             a_empty;
  logic             a_aempty;

  logic             b_winc;
  logic [DSIZE-1:0] b_wdata;
  logic             b_rinc;
  logic [DSIZE-1:0] b_rdata;
  logic             b_full;
  logic             b_afull;
  logic             b_empty;
  logic             b_aempty;

  logic [ASIZE:0]   level;
  logic             err;

  modport slave (
    input  dir_req,
    input  a_winc, a_wdata, a_rinc,
    input  b_winc, b_wdata, b_rinc,
    output dir, dir_busy,
    output a_rdata, a_full, a_afull,
    output a_empty, a_aempty,
    output b_rdata, b_full, b_afull,
    output b_empty, b_aempty,
    output level, err
  );

  modport master (
    output dir_req,
    output a_winc, a_wdata, a_rinc,
    output b_winc, b_wdata, b_rinc,
    input  dir, dir_busy,
    input  a_rdata, a_full, a_afull,
    input  a_empty, a_aempty,
    input  b_rdata, b_full, b_afull,
    input  b_empty, b_aempty,
    input  level, err
  );

endinterface

// File: rtl/sync_bidir_fifo_core.sv
// Single-direction FIFO core: RAM, pointers, level and registered flags.
// SYNC_BIDIR_FIFO_FWFT_EN selects first-word fall-through read data.
module sync_fifo_core
  import bidir_fifo_pkg::*;
#(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 4,
  parameter int AFULL_LVL  = 14,
  parameter int AEMPTY_LVL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             winc,
  input  logic             rinc,
  input  logic [DSIZE-1:0] wdata,
  output logic [DSIZE-1:0] rdata,
  output logic             full,
  output logic             afull,
  output logic             empty,
  output logic             aempty,
  output logic [ASIZE:0]   level
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] LV_MAX = DEPTH[ASIZE:0];
  localparam logic [ASIZE:0] LV_AF  = AFULL_LVL[ASIZE:0];
  localparam logic [ASIZE:0] LV_AE  = AEMPTY_LVL[ASIZE:0];

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE-1:0] wptr;
  logic [ASIZE-1:0] rptr;
  logic [ASIZE:0]   lvl_q;
  logic [ASIZE:0]   lvl_nxt;
  logic             full_q;
  logic             afull_q;
  logic             empty_q;
  logic             aempty_q;
  logic             wr;
  logic             rd;

  // Flags are registered, so a write at full or a read at empty is dropped
  assign wr = winc & ~full_q;
  assign rd = rinc & ~empty_q;

  always_comb begin
    lvl_nxt = lvl_q;
    unique case ({wr, rd})
      2'b10:   lvl_nxt = lvl_q + 1'b1;
      2'b01:   lvl_nxt = lvl_q - 1'b1;
      default: lvl_nxt = lvl_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      lvl_q    <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
    end else if (clr) begin
      wptr     <= '0;
      rptr     <= '0;
      lvl_q    <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      lvl_q    <= lvl_nxt;
      full_q   <= (lvl_nxt == LV_MAX);
      afull_q  <= (lvl_nxt >= LV_AF);
      empty_q  <= (lvl_nxt == '0);
      aempty_q <= (lvl_nxt <= LV_AE);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

`ifdef SYNC_BIDIR_FIFO_FWFT_EN
  assign rdata = empty_q ? '0 : mem[rptr];
`else
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rd) begin
      rdata_q <= mem[rptr];
    end
  end

  assign rdata = rdata_q;
`endif

  assign full   = full_q;
  assign afull  = afull_q;
  assign empty  = empty_q;
  assign aempty = aempty_q;
  assign level  = lvl_q;

endmodule

// File: rtl/sync_bidir_fifo.sv
// Bidirectional FIFO top: turnaround FSM, port steering and sticky err.
// SYNC_BIDIR_FIFO_FWFT_EN selects first-word fall-through read data.
module sync_bidir_fifo
  import bidir_fifo_pkg::*;
#(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 4,
  parameter int AFULL_LVL  = 14,
  parameter int AEMPTY_LVL = 2
) (
  input logic                clk,
  input logic                rst_n,
  sync_bidir_fifo_if.slave   bus
);

  state_t           state;
  logic             dir_q;
  logic             busy_q;
  logic             err_q;
  logic             steady;
  logic             a_wr;
  logic             drain_done;
  logic             misuse;

  logic             c_clr;
  logic             c_winc;
  logic             c_rinc;
  logic [DSIZE-1:0] c_wdata;
  logic [DSIZE-1:0] c_rdata;
  logic             c_full;
  logic             c_afull;
  logic             c_empty;
  logic             c_aempty;
  logic [ASIZE:0]   c_level;

  logic             a_full;
  logic             a_empty;
  logic             b_full;
  logic             b_empty;

  assign steady = (state == ST_A2B) | (state == ST_B2A);
  assign a_wr   = (dir_q == DIR_A_WRITES);

  // Writer reports full for the whole turnaround so its writes are refused
  assign a_full  = a_wr ? (c_full | ~steady) : 1'b1;
  assign b_full  = a_wr ? 1'b1 : (c_full | ~steady);
  assign a_empty = a_wr ? 1'b1 : c_empty;
  assign b_empty = a_wr ? c_empty : 1'b1;

  assign c_winc  = a_wr ? (bus.a_winc & ~a_full)
                        : (bus.b_winc & ~b_full);
  assign c_rinc  = a_wr ? (bus.b_rinc & ~b_empty)
                        : (bus.a_rinc & ~a_empty);
  assign c_wdata = a_wr ? bus.a_wdata : bus.b_wdata;
  assign c_clr   = (state == ST_TURN);

  // Forced flags fold wrong-side strobes into the full/empty misuse terms
  assign misuse = (bus.a_winc & a_full)
                | (bus.b_winc & b_full)
                | (bus.a_rinc & a_empty)
                | (bus.b_rinc & b_empty);

  assign drain_done =
    ((c_level - {{ASIZE{1'b0}}, c_rinc}) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_A2B;
      dir_q  <= DIR_A_WRITES;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_q | misuse;
      unique case (state)
        ST_A2B, ST_B2A: begin
          if (bus.dir_req != dir_q) begin
            state  <= ST_DRAIN;
            busy_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (bus.dir_req == dir_q) begin
            state  <= steady_of(dir_q);
            busy_q <= 1'b0;
          end else if (drain_done) begin
            state  <= ST_TURN;
          end
        end
        ST_TURN: begin
          state  <= steady_of(~dir_q);
          dir_q  <= ~dir_q;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_A2B;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo_core #(
    .DSIZE      (DSIZE),
    .ASIZE      (ASIZE),
    .AFULL_LVL  (AFULL_LVL),
    .AEMPTY_LVL (AEMPTY_LVL)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (c_clr),
    .winc   (c_winc),
    .rinc   (c_rinc),
    .wdata  (c_wdata),
    .rdata  (c_rdata),
    .full   (c_full),
    .afull  (c_afull),
    .empty  (c_empty),
    .aempty (c_aempty),
    .level  (c_level)
  );

  assign bus.dir      = dir_q;
  assign bus.dir_busy = busy_q;
  assign bus.err      = err_q;
  assign bus.level    = c_level;

  assign bus.a_full   = a_full;
  assign bus.a_afull  = a_wr ? c_afull : 1'b1;
  assign bus.a_empty  = a_empty;
  assign bus.a_aempty = a_wr ? 1'b1 : c_aempty;
  assign bus.a_rdata  = a_wr ? '0 : c_rdata;

  assign bus.b_full   = b_full;
  assign bus.b_afull  = a_wr ? 1'b1 : c_afull;
  assign bus.b_empty  = b_empty;
  assign bus.b_aempty = a_wr ? c_aempty : 1'b1;
  assign bus.b_rdata  = a_wr ? c_rdata : '0;

endmodule
